// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int ZERO_ADDR      = 0;

  // The pending counter must hold DEPTH itself, so it needs one extra bit.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits, issue back-pressure and the pending-write count.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int ZERO_REG   = 1,
  localparam int DEPTH      = 2 ** ADDR_WIDTH,
  localparam int CW         = cnt_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  output logic                  iss_ready,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DEPTH-1:0]      busy,
  output logic [CW-1:0]         pending_cnt
);

  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;
  logic [DEPTH-1:0] set_vec_s;
  logic [DEPTH-1:0] clr_vec_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic             ready_s;
  logic             set_en_s;
  logic             inc_s;
  logic             dec_s;

  // Next busy vector and count; the count moves only on real bit transitions.
  always_comb begin
    set_vec_s = '0;
    clr_vec_s = '0;
    ready_s   = !busy_r[iss_addr] || (wb_valid && (wb_addr == iss_addr));
    set_en_s  = iss_valid && ready_s &&
                !((ZERO_REG != 0) && (iss_addr == ADDR_WIDTH'(ZERO_ADDR)));
    if (set_en_s) begin
      set_vec_s[iss_addr] = 1'b1;
    end else begin
      set_vec_s = '0;
    end
    if (wb_valid) begin
      clr_vec_s[wb_addr] = 1'b1;
    end else begin
      clr_vec_s = '0;
    end
    inc_s      = set_en_s && !busy_r[iss_addr];
    dec_s      = wb_valid && busy_r[wb_addr] && !(set_en_s && (iss_addr == wb_addr));
    busy_nxt_s = (busy_r & ~clr_vec_s) | set_vec_s;
    cnt_nxt_s  = cnt_r + CW'(inc_s) - CW'(dec_s);
  end

  // Busy vector and pending count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= '0;
      cnt_r  <= '0;
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign iss_ready   = ready_s;
  assign busy        = busy_r;
  assign pending_cnt = cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with integrated scoreboard.
// Define REGFILE_BYPASS_EN to forward a writeback to same-cycle reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int NUM_RD     = 2,
  parameter  int ZERO_REG   = 1,
  localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]     rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  input  logic                             iss_valid,
  input  logic [ADDR_WIDTH-1:0]            iss_addr,
  output logic                             iss_ready,
  input  logic                             wb_valid,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0]            wb_data,
  output logic [cnt_width(ADDR_WIDTH)-1:0] pending_cnt
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]      busy_s;

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .iss_valid   (iss_valid),
    .iss_addr    (iss_addr),
    .iss_ready   (iss_ready),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .busy        (busy_s),
    .pending_cnt (pending_cnt)
  );

  // Storage array; register 0 is never written when hardwired to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (wb_valid && !((ZERO_REG != 0) && (wb_addr == ADDR_WIDTH'(ZERO_ADDR)))) begin
        mem_r[wb_addr] <= wb_data;
      end
    end
  end

  genvar k;
  for (k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  busy_b_s;
    logic                  zero_s;

    assign addr_s = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign zero_s = (ZERO_REG != 0) && (addr_s == ADDR_WIDTH'(ZERO_ADDR));

    // Combinational read mux for one port.
    always_comb begin
      data_s   = mem_r[addr_s];
      busy_b_s = busy_s[addr_s];
      if (zero_s) begin
        data_s   = '0;
        busy_b_s = 1'b0;
      end else begin
        data_s   = mem_r[addr_s];
        busy_b_s = busy_s[addr_s];
      end
`ifdef REGFILE_BYPASS_EN
      if (!rst && wb_valid && (wb_addr == addr_s) && !zero_s) begin
        data_s   = wb_data;
        busy_b_s = 1'b0;
      end else begin
        data_s   = data_s;
        busy_b_s = busy_b_s;
      end
`endif
    end

    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data_s;
    assign rd_busy[k]                          = busy_b_s;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (3 read ports).
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_busy;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [5:0]  pending_cnt;

  int checks = 0;
  int errors = 0;

  regfile_sb #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .NUM_RD     (3),
    .ZERO_REG   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .iss_valid   (iss_valid),
    .iss_addr    (iss_addr),
    .iss_ready   (iss_ready),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    wb_valid  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    rd_addr   = 15'd0;
    iss_valid = 1'b0;
    iss_addr  = 5'd0;
    wb_valid  = 1'b0;
    wb_addr   = 5'd0;
    wb_data   = 32'd0;
    #12;
    rst = 1'b0;
    #1;
    chk("reset_data", {32'd0, rd_data[31:0]}, 64'd0);
    chk("reset_busy", {61'd0, rd_busy}, 64'd0);
    chk("reset_pending", {58'd0, pending_cnt}, 64'd0);
    chk("reset_ready", {63'd0, iss_ready}, 64'd1);

    // Claim 5 then write it back.
    rd_addr   = {5'd5, 5'd5, 5'd5};
    iss_valid = 1'b1;
    iss_addr  = 5'd5;
    #1;
    chk("claim5_ready", {63'd0, iss_ready}, 64'd1);
    tick();
    idle();
    #1;
    chk("claim5_busy", {61'd0, rd_busy}, 64'd7);
    chk("claim5_pending", {58'd0, pending_cnt}, 64'd1);
    wb_valid = 1'b1;
    wb_addr  = 5'd5;
    wb_data  = 32'hDEADBEEF;
    #1;
    chk("wb5_same_data", {32'd0, rd_data[31:0]}, BYP ? 64'hDEADBEEF : 64'd0);
    chk("wb5_same_busy", {63'd0, rd_busy[0]}, BYP ? 64'd0 : 64'd1);
    tick();
    idle();
    #1;
    chk("wb5_next_data", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
    chk("wb5_next_busy", {61'd0, rd_busy}, 64'd0);
    chk("wb5_next_pending", {58'd0, pending_cnt}, 64'd0);

    // WAW stall on 9.
    rd_addr   = {5'd9, 5'd9, 5'd9};
    iss_valid = 1'b1;
    iss_addr  = 5'd9;
    tick();
    #1;
    chk("waw_stall1", {63'd0, iss_ready}, 64'd0);
    chk("waw_pending1", {58'd0, pending_cnt}, 64'd1);
    tick();
    #1;
    chk("waw_stall2", {63'd0, iss_ready}, 64'd0);
    wb_valid = 1'b1;
    wb_addr  = 5'd9;
    wb_data  = 32'h00000099;
    #1;
    chk("waw_release_ready", {63'd0, iss_ready}, 64'd1);
    tick();
    idle();
    #1;
    chk("waw_busy_kept", {63'd0, rd_busy[0]}, 64'd1);
    chk("waw_pending_kept", {58'd0, pending_cnt}, 64'd1);
    chk("waw_data", {32'd0, rd_data[31:0]}, 64'h99);
    wb_valid = 1'b1;
    wb_addr  = 5'd9;
    wb_data  = 32'h00000077;
    tick();
    idle();
    #1;
    chk("waw_final_pending", {58'd0, pending_cnt}, 64'd0);
    chk("waw_final_busy", {61'd0, rd_busy}, 64'd0);

    // Zero register: write and claim x0 in the same cycle.
    rd_addr   = 15'd0;
    wb_valid  = 1'b1;
    wb_addr   = 5'd0;
    wb_data   = 32'h00001234;
    iss_valid = 1'b1;
    iss_addr  = 5'd0;
    #1;
    chk("zero_ready", {63'd0, iss_ready}, 64'd1);
    chk("zero_same_data", {32'd0, rd_data[31:0]}, 64'd0);
    tick();
    idle();
    #1;
    chk("zero_data", {32'd0, rd_data[63:32]}, 64'd0);
    chk("zero_busy", {61'd0, rd_busy}, 64'd0);
    chk("zero_pending", {58'd0, pending_cnt}, 64'd0);

    // Multi-port reads after writes to non-busy registers.
    wb_valid = 1'b1;
    wb_addr  = 5'd1;
    wb_data  = 32'h000000A5;
    tick();
    wb_addr  = 5'd31;
    wb_data  = 32'hFFFFFFFF;
    tick();
    idle();
    rd_addr = {5'd31, 5'd1, 5'd1};
    #1;
    chk("mp_port0", {32'd0, rd_data[31:0]}, 64'hA5);
    chk("mp_port1", {32'd0, rd_data[63:32]}, 64'hA5);
    chk("mp_port2", {32'd0, rd_data[95:64]}, 64'hFFFFFFFF);
    chk("mp_pending", {58'd0, pending_cnt}, 64'd0);

    // Bypass path on 4, first claimed so busy is visible.
    rd_addr   = {5'd1, 5'd4, 5'd4};
    iss_valid = 1'b1;
    iss_addr  = 5'd4;
    tick();
    idle();
    #1;
    chk("byp_claim_busy", {61'd0, rd_busy}, 64'd3);
    wb_valid = 1'b1;
    wb_addr  = 5'd4;
    wb_data  = 32'h00000055;
    #1;
    chk("byp_same_data", {32'd0, rd_data[31:0]}, BYP ? 64'h55 : 64'd0);
    chk("byp_same_busy", {61'd0, rd_busy}, BYP ? 64'd0 : 64'd3);
    tick();
    idle();
    #1;
    chk("byp_next_data", {32'd0, rd_data[63:32]}, 64'h55);
    chk("byp_next_pending", {58'd0, pending_cnt}, 64'd0);

    // Reset mid-traffic with two claims outstanding.
    iss_valid = 1'b1;
    iss_addr  = 5'd3;
    tick();
    iss_addr  = 5'd7;
    tick();
    idle();
    rd_addr = {5'd7, 5'd3, 5'd5};
    #1;
    chk("pre_rst_pending", {58'd0, pending_cnt}, 64'd2);
    chk("pre_rst_busy", {61'd0, rd_busy}, 64'd6);
    chk("pre_rst_data", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
    rst = 1'b1;
    #1;
    chk("rst_async_data", {32'd0, rd_data[31:0]}, 64'd0);
    chk("rst_async_busy", {61'd0, rd_busy}, 64'd0);
    chk("rst_async_pending", {58'd0, pending_cnt}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {63'd0, iss_ready}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
